// File: rtl/rv_plic_target.sv
// rv_plic_target: per-target PLIC stage sitting after the interrupt gateway.
// Picks the highest-priority enabled pending source above the target
// threshold, drives a registered irq/irq_id, and emits one-cycle claim and
// complete pulses back to the gateway.
//
// Source index i carries interrupt ID i+1; ID 0 means "no interrupt".
//
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   ip, ie         pending bits from gateway, per-source enable
//   prio           priority of source i at [i*PRIOW +: PRIOW]
//   threshold      target priority threshold
//   claim_req      claim-register read strobe
//   complete_req   claim-register write strobe, with complete_id
//   irq, irq_id    interrupt request and winning ID (0 when irq=0)
//   claim_ack      one-cycle claim response, claim_id valid with it
//   claim          one-hot claim pulse to gateway
//   complete       one-hot complete pulse to gateway
//
// Configuration:
//   RV_PLIC_TARGET_PIPE_EN  registers the two half-tree winners, making the
//                           irq/irq_id latency 2 cycles and the claim settle
//                           window 2 cycles. Undefined: single-stage arbiter.
module rv_plic_target #(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned MAX_PRIO = 7,
  parameter int unsigned PRIOW    = $clog2(MAX_PRIO + 1),
  parameter int unsigned SRCW     = $clog2(N_SOURCE + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_SOURCE-1:0]       ip,
  input  logic [N_SOURCE-1:0]       ie,
  input  logic [N_SOURCE*PRIOW-1:0] prio,
  input  logic [PRIOW-1:0]          threshold,
  input  logic                      claim_req,
  input  logic                      complete_req,
  input  logic [SRCW-1:0]           complete_id,
  output logic                      irq,
  output logic [SRCW-1:0]           irq_id,
  output logic                      claim_ack,
  output logic [SRCW-1:0]           claim_id,
  output logic [N_SOURCE-1:0]       claim,
  output logic [N_SOURCE-1:0]       complete
);

  localparam int unsigned Half = N_SOURCE / 2;

  // ---------------------------------------------------------------------------
  // Arbitration, first half: best source in each half of the index range.
  // Strict '>' keeps the lowest index on ties and never lets prio 0 win.
  // ---------------------------------------------------------------------------
  logic [PRIOW-1:0] lo_prio, hi_prio, p_cur;
  logic [SRCW-1:0]  lo_id, hi_id;

  always_comb begin
    lo_prio = '0;
    lo_id   = '0;
    hi_prio = '0;
    hi_id   = '0;
    p_cur   = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      p_cur = prio[i*PRIOW +: PRIOW];
      if (ip[i] && ie[i]) begin
        if (i < Half) begin
          if (p_cur > lo_prio) begin
            lo_prio = p_cur;
            lo_id   = SRCW'(i + 1);
          end
        end else if (p_cur > hi_prio) begin
          hi_prio = p_cur;
          hi_id   = SRCW'(i + 1);
        end
      end
    end
  end

  logic [PRIOW-1:0] s2_lo_prio, s2_hi_prio, s2_thr;
  logic [SRCW-1:0]  s2_lo_id, s2_hi_id;

`ifdef RV_PLIC_TARGET_PIPE_EN
  logic [PRIOW-1:0] lo_prio_q, hi_prio_q, thr_q;
  logic [SRCW-1:0]  lo_id_q, hi_id_q;

  // Threshold travels with the half winners so its latency matches ip/prio.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lo_prio_q <= '0;
      hi_prio_q <= '0;
      thr_q     <= '0;
      lo_id_q   <= '0;
      hi_id_q   <= '0;
    end else begin
      lo_prio_q <= lo_prio;
      hi_prio_q <= hi_prio;
      thr_q     <= threshold;
      lo_id_q   <= lo_id;
      hi_id_q   <= hi_id;
    end
  end

  assign s2_lo_prio = lo_prio_q;
  assign s2_hi_prio = hi_prio_q;
  assign s2_thr     = thr_q;
  assign s2_lo_id   = lo_id_q;
  assign s2_hi_id   = hi_id_q;
`else
  assign s2_lo_prio = lo_prio;
  assign s2_hi_prio = hi_prio;
  assign s2_thr     = threshold;
  assign s2_lo_id   = lo_id;
  assign s2_hi_id   = hi_id;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration, final merge and threshold compare.
  // ---------------------------------------------------------------------------
  logic [PRIOW-1:0] win_prio;
  logic [SRCW-1:0]  win_id;
  logic             irq_d, irq_q;
  logic [SRCW-1:0]  irq_id_d, irq_id_q;

  always_comb begin
    win_prio = s2_lo_prio;
    win_id   = s2_lo_id;
    // Upper half only wins when strictly higher: ties stay with lower index.
    if (s2_hi_prio > s2_lo_prio) begin
      win_prio = s2_hi_prio;
      win_id   = s2_hi_id;
    end
    irq_d    = (win_prio > s2_thr);
    irq_id_d = irq_d ? win_id : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;

  // ---------------------------------------------------------------------------
  // Claim FSM: Idle -> Ack -> Settle (-> Settle2 when pipelined) -> Idle.
  // The settle window lets the gateway drop ip and the arbiter catch up before
  // the next claim samples irq_id.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StAck, StSettle, StSettle2} claim_st_e;

  claim_st_e       state_q, state_d;
  logic            pending_q, pending_d;
  logic [SRCW-1:0] cap_q, cap_d;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cap_d     = cap_q;
    unique case (state_q)
      StIdle: begin
        if (claim_req || pending_q) begin
          cap_d     = irq_id_q;
          pending_d = 1'b0;
          state_d   = StAck;
        end
      end
      StAck: begin
        if (claim_req) pending_d = 1'b1;
        state_d = StSettle;
      end
      StSettle: begin
        if (claim_req) pending_d = 1'b1;
`ifdef RV_PLIC_TARGET_PIPE_EN
        state_d = StSettle2;
`else
        state_d = StIdle;
`endif
      end
      StSettle2: begin
        if (claim_req) pending_d = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cap_q     <= cap_d;
    end
  end

  assign claim_ack = (state_q == StAck);
  assign claim_id  = claim_ack ? cap_q : '0;

  // ID 0 matches no bit, so an empty claim pulses nothing.
  always_comb begin
    claim = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      claim[i] = claim_ack && (cap_q == SRCW'(i + 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Complete path: independent of the claim FSM. Out-of-range IDs (0 or
  // above N_SOURCE) match no bit and are dropped.
  // ---------------------------------------------------------------------------
  logic [N_SOURCE-1:0] complete_d, complete_q;

  always_comb begin
    complete_d = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      complete_d[i] = complete_req && (complete_id == SRCW'(i + 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) complete_q <= '0;
    else         complete_q <= complete_d;
  end

  assign complete = complete_q;

endmodule
